// File: rtl/path_stack_replay.sv
// LIFO of move codes, with a replay engine that streams the frozen stack
// from bottom to top over a valid/ready channel.
module path_stack_replay #(
    parameter int DATA_W = 2,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] top,
    output logic [PTR_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              err_ovf,
    output logic              err_unf,
    input  logic              replay_start,
    input  logic              replay_ready,
    output logic              replay_valid,
    output logic              replay_last,
    output logic              replay_busy,
    output logic [DATA_W-1:0] replay_data,
    output logic              replay_done
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t            state, state_nx;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  count_q, count_nx, top_ptr;
    logic [PTR_W-1:0]  idx, idx_nx, len, len_nx;
    logic              wr_en, ovf_nx, unf_nx;
    logic [AW-1:0]     wr_addr;
    logic              unused_bits;

    assign top_ptr     = count_q - PTR_W'(1);
    assign count       = count_q;
    assign empty       = (count_q == '0);
    assign full        = (count_q == PTR_W'(DEPTH));
    assign top         = empty ? '0 : mem[top_ptr[AW-1:0]];
    assign unused_bits = ^top_ptr;

    // Stack update; all of it is frozen while a replay is in flight.
    always_comb begin
        count_nx = count_q;
        wr_en    = 1'b0;
        wr_addr  = count_q[AW-1:0];
        ovf_nx   = 1'b0;
        unf_nx   = 1'b0;
        if (!replay_busy) begin
            if (clear) begin
                count_nx = '0;
            end else if (push && pop && !empty) begin
                wr_en   = 1'b1;
                wr_addr = top_ptr[AW-1:0];
            end else if (push && !full) begin
                wr_en    = 1'b1;
                count_nx = count_q + PTR_W'(1);
            end else if (push && !pop) begin
                ovf_nx = 1'b1;
            end else if (pop) begin
                if (empty) unf_nx = 1'b1;
                else       count_nx = count_q - PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
            state   <= IDLE;
            idx     <= '0;
            len     <= '0;
        end else begin
            count_q <= count_nx;
            err_ovf <= ovf_nx;
            err_unf <= unf_nx;
            state   <= state_nx;
            idx     <= idx_nx;
            len     <= len_nx;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        len_nx   = len;
        case (state)
            IDLE: if (replay_start) begin
                if (count_q != '0) begin
                    state_nx = STREAM;
                    idx_nx   = '0;
                    len_nx   = count_q;
                end else begin
                    state_nx = DONE;
                end
            end
            STREAM: if (replay_ready) begin
                idx_nx = idx + PTR_W'(1);
                if (replay_last) state_nx = DONE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign replay_valid = (state == STREAM);
    assign replay_last  = replay_valid && (idx == len - PTR_W'(1));
    assign replay_data  = replay_valid ? mem[idx[AW-1:0]] : '0;
    assign replay_busy  = (state != IDLE);
    assign replay_done  = (state == DONE);
endmodule

// File: doc/path_stack_replay.md
PATH_STACK_REPLAY -- requirements
Module: path_stack_replay

Interface
REQ-001 The block SHALL have parameter DATA_W, default 2: width of one stored entry (one move code).
REQ-002 The block SHALL have parameter DEPTH, default 16: maximum number of entries.
REQ-003 The block SHALL have parameter PTR_W, default 5: width of count and indices, at least clog2(DEPTH)+1.
REQ-004 The block SHALL have port clk, input, 1: rising-edge clock.
REQ-005 The block SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 The block SHALL have port clear, input, 1: synchronous flush of stack contents and count.
REQ-007 The block SHALL have port push, input, 1: write din on top of the stack.
REQ-008 The block SHALL have port pop, input, 1: remove the top entry.
REQ-009 The block SHALL have port din, input, DATA_W: data to push.
REQ-010 The block SHALL have port top, output, DATA_W: current top entry.
REQ-011 The block SHALL have port count, output, PTR_W: number of stored entries.
REQ-012 The block SHALL have ports empty and full, output, 1 each: stack status flags.
REQ-013 The block SHALL have ports err_ovf and err_unf, output, 1 each: single-cycle error pulses.
REQ-014 The block SHALL have port replay_start, input, 1: request to stream the stack from bottom to top.
REQ-015 The block SHALL have port replay_ready, input, 1: consumer ready.
REQ-016 The block SHALL have ports replay_valid, replay_last and replay_busy, output, 1 each; and port replay_data, output, DATA_W.
REQ-017 The block SHALL have port replay_done, output, 1: single-cycle pulse when a replay completes.

Function
REQ-018 Storage SHALL be DEPTH x DATA_W registers; count SHALL be the stack pointer; empty SHALL equal (count==0); full SHALL equal (count==DEPTH).
REQ-019 top SHALL equal entry[count-1], and SHALL be 0 when the stack is empty (combinational).
REQ-020 Push only, not full: entry[count] is set to din and count increments at the clock edge.
REQ-021 Pop only, not empty: count decrements; the stored data is not cleared.
REQ-022 Push and pop together, not empty: entry[count-1] is set to din and count is unchanged (replace top).
REQ-023 Push and pop together, empty: the operation is treated as push only; err_unf is not raised.
REQ-024 Push when full with no pop: the push is ignored and err_ovf pulses high for one cycle.
REQ-025 Pop when empty with no push: the pop is ignored and err_unf pulses high for one cycle.
REQ-026 clear SHALL have priority over push and pop: count goes to 0 the next cycle and no error pulse is raised.
REQ-027 While replay_busy=1, push, pop and clear SHALL be ignored with no error pulse; stack contents stay frozen.
REQ-028 The replay FSM SHALL have states IDLE, STREAM and DONE.
REQ-029 IDLE -> STREAM occurs on replay_start when count>0; the index is loaded with 0 and a snapshot of count is latched as len.
REQ-030 IDLE -> DONE occurs on replay_start when count==0; no beats are produced.
REQ-031 In STREAM: replay_valid=1; replay_data=entry[idx]; replay_last=(idx==len-1).
REQ-032 In STREAM, a beat transfers on replay_valid & replay_ready; idx increments by 1 per transfer; without ready, data and idx SHALL hold.
REQ-033 On the transfer with replay_last=1, the FSM moves STREAM -> DONE.
REQ-034 DONE SHALL last exactly one cycle with replay_done=1, then return to IDLE.
REQ-035 replay_busy SHALL be 1 in STREAM and DONE; replay_start is ignored outside IDLE.
REQ-036 The first beat SHALL be valid in the cycle after replay_start is sampled; with ready held high, one beat transfers per cycle.
REQ-037 In IDLE, replay_valid, replay_last and replay_data SHALL be 0.

Reset
REQ-038 While rst=1: count=0, empty=1, full=0, err_ovf=err_unf=0, FSM=IDLE, idx=len=0, replay_* outputs=0, top=0.
REQ-039 Reset asserted mid-replay SHALL abort the replay immediately with no replay_done pulse; storage contents need not be cleared.

Verification
REQ-040 Push 1,2,3 then pop -> top sequence 1,2,3,2; count 1,2,3,2; no error pulses.
REQ-041 Push 16 entries (default params), then push 0 -> full=1, count stays 16, err_ovf=1 for one cycle; pop on empty -> err_unf=1, count=0.
REQ-042 count=2, top=1, push+pop with din=3 -> count=2, top=3.
REQ-043 Push 0,1,2,3, replay_start, replay_ready held high -> beats 0,1,2,3 on 4 consecutive cycles starting 1 cycle after start; replay_last on beat 3; replay_done the next cycle; pushes during replay ignored.
REQ-044 Replay with replay_ready toggling 1,0,1,0 -> each beat held stable while ready=0, order preserved; replay_start with count=0 -> no valid, replay_done one cycle later.
REQ-045 rst pulsed during STREAM after 2 beats -> all outputs at reset values the same cycle, replay_done never asserted.
